spi_controller: RTL and testbench
=================================

// Module: spi_controller
// PURPOSE
//  Sequencing FSM for the SPI datapath (shift registers + TX/RX FIFOs). Generates SCLK from a
//  programmable divider and drives CS_N. Issues the per-edge load/shift/sample/write strobes
//  for CPOL/CPHA modes 0-3. Sits between the SPI register block and spi_datapath.
// PARAMETERS
//  CLK_DIV_W   8   width of clk_div_i; SCLK half-period = clk_div_i+1 clk cycles
// PORTS
//  clk                 in   1          system clock, all logic on posedge
//  rst_n               in   1          reset, synchronous, active-low
//  spi_en_i            in   1          enable; low aborts any transfer
//  cpol_i              in   1          SCLK idle level
//  cpha_i              in   1          0: sample leading edge; 1: sample trailing edge
//  clk_div_i           in   CLK_DIV_W  half-period minus one, in clk cycles
//  tx_fifo_empty_i     in   1          from datapath TX FIFO
//  tx_shift_load_o     out  1          load TX shift reg from TX FIFO head
//  tx_fifo_read_o      out  1          pop TX FIFO
//  mosi_first_en_o     out  1          present first bit (CPHA=0 only)
//  mosi_transmit_en_o  out  1          shift next bit onto MOSI
//  miso_en_o           out  1          sample MISO into RX shift reg
//  mosi_mux_sel_o      out  1          1 = MOSI driven from shift reg, 0 = MOSI forced 0
//  rx_fifo_write_o     out  1          push RX shift reg into RX FIFO
//  sclk_o              out  1          SPI clock
//  cs_n_o              out  1          chip select, active-low
//  busy_o              out  1          high in any state except IDLE
//  xfer_done_o         out  1          1-cycle pulse per completed byte
// BEHAVIOUR
//  Reset (rst_n low at posedge): state=IDLE, cs_n_o=1, sclk_o=0, busy_o=0, all strobes 0, counters 0.
//  In IDLE, sclk_o=cpol_i registered.
//  cpol/cpha/clk_div latch in LOAD. Mid-transfer changes take effect at the next LOAD.
//  Divider: div_cnt counts 0..clk_div_q. A tick fires on the cycle div_cnt==clk_div_q, then div_cnt returns to 0.
//  Divider is cleared on each state entry.
//  FSM states:
//   IDLE  -> LOAD when spi_en_i & !tx_fifo_empty_i.
//   LOAD  (1 cycle): tx_shift_load_o=tx_fifo_read_o=1, cs_n_o->0, mosi_mux_sel_o->1.
//         Next state SETUP.
//   SETUP (1 half-period, CS setup): mosi_first_en_o=1 on the first cycle when cpha_q=0.
//         On tick -> SHIFT.
//   SHIFT: sclk toggles on every tick; 16 edges total, counted by a 4-bit edge_cnt.
//    - Sample edges carry miso_en_o=1 in the toggle cycle: odd edges when cpha_q=0, even edges when cpha_q=1.
//    - Shift edges carry mosi_transmit_en_o=1: even edges 2..14 when cpha_q=0; odd edges 1..15 when cpha_q=1.
//    - No shift on edge 16 in mode CPHA=0.
//    - After edge 16 -> HOLD; sclk_o is back at cpol_q.
//   HOLD  (1 half-period): rx_fifo_write_o=1 on the first cycle. On tick -> GAP.
//   GAP   (1 half-period): cs_n_o=1, mosi_mux_sel_o=0, xfer_done_o=1 on the first cycle.
//         On tick -> LOAD if spi_en_i & !tx_fifo_empty_i, else IDLE.
//  Back-to-back bytes: CS_N deasserts for exactly one half-period between bytes.
//  Abort: spi_en_i low in any non-IDLE state -> IDLE next cycle. cs_n_o=1, sclk_o=cpol_q, no rx_fifo_write_o.
//    A byte already popped is lost.
//  All outputs are registered. Strobes are single-cycle and mutually exclusive per cycle,
//  except tx_shift_load_o/tx_fifo_read_o, which always pulse together.
//  clk_div_i=0 gives SCLK=clk/2; the maximum value gives half-period 2^CLK_DIV_W.
// TESTING
//  T1 mode0, clk_div=0, TX 0xA5, MOSI looped to MISO:
//     16 SCLK edges, each 1 clk apart; one rx_fifo_write_o; RX FIFO holds 0xA5; one xfer_done_o.
//  T2 mode3, clk_div=3, TX 0x3C, loopback:
//     SCLK idles 1, high/low phases 4 clk each; miso_en_o on rising edges; RX 0x3C.
//  T3 two bytes 0x11, 0x22 queued:
//     two tx_fifo_read_o pulses; cs_n_o high for clk_div+1 cycles between bytes; RX 0x11 then 0x22.
//  T4 spi_en_i=1 with an empty TX FIFO: stays IDLE, cs_n_o=1, busy_o=0, no strobes for 100 cycles.
//  T5 drop spi_en_i after edge 5: next cycle cs_n_o=1, sclk_o=cpol; no rx_fifo_write_o; busy_o=0.
//  T6 assert rst_n=0 for 1 cycle mid-SHIFT: outputs reach reset values at that posedge, not before.

Source files
------------

// File: rtl/spi_controller.sv
// SPI sequencing FSM: divides clk into SCLK, frames CS_N and issues the per-edge
// load/shift/sample/write strobes for CPOL/CPHA modes 0-3. All outputs registered.
module spi_controller #(
   parameter int CLK_DIV_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 spi_en_i,
   input  logic                 cpol_i,
   input  logic                 cpha_i,
   input  logic [CLK_DIV_W-1:0] clk_div_i,
   input  logic                 tx_fifo_empty_i,
   output logic                 tx_shift_load_o,
   output logic                 tx_fifo_read_o,
   output logic                 mosi_first_en_o,
   output logic                 mosi_transmit_en_o,
   output logic                 miso_en_o,
   output logic                 mosi_mux_sel_o,
   output logic                 rx_fifo_write_o,
   output logic                 sclk_o,
   output logic                 cs_n_o,
   output logic                 busy_o,
   output logic                 xfer_done_o
);

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t               state, next_state;
   logic [CLK_DIV_W-1:0] div_cnt, clk_div_q;
   logic [3:0]           edge_cnt;
   logic                 cpol_q, cpha_q;
   logic                 tick, start, abort;

   logic load_d, first_d, transmit_d, miso_d, mux_d, rxw_d, sclk_d, cs_n_d, busy_d, done_d;

   assign tick  = (div_cnt == clk_div_q);
   assign start = spi_en_i && !tx_fifo_empty_i;
   assign abort = (state != IDLE) && !spi_en_i;

   // State, divider, edge counter and per-byte configuration snapshot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         div_cnt   <= '0;
         edge_cnt  <= '0;
         clk_div_q <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state != state || tick || state == IDLE)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + 1'b1;
         if (state != SHIFT)
            edge_cnt <= '0;
         else if (tick)
            edge_cnt <= edge_cnt + 4'd1;
         if (next_state == LOAD) begin
            clk_div_q <= clk_div_i;
            cpol_q    <= cpol_i;
            cpha_q    <= cpha_i;
         end
      end
   end

   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = SETUP;
            SETUP:   if (tick) next_state = SHIFT;
            SHIFT:   if (tick && edge_cnt == 4'd15) next_state = HOLD;
            HOLD:    if (tick) next_state = GAP;
            GAP:     if (tick) next_state = start ? LOAD : IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Next values of the output registers
   always_comb begin
      load_d     = 1'b0;
      first_d    = 1'b0;
      transmit_d = 1'b0;
      miso_d     = 1'b0;
      rxw_d      = 1'b0;
      done_d     = 1'b0;
      mux_d      = 1'b1;
      cs_n_d     = 1'b0;
      sclk_d     = cpol_q;
      busy_d     = (next_state != IDLE);
      case (state)
         IDLE: begin
            mux_d  = 1'b0;
            cs_n_d = 1'b1;
            sclk_d = cpol_i;
         end
         LOAD:  load_d  = 1'b1;
         SETUP: first_d = !cpha_q && (div_cnt == '0);
         SHIFT: begin
            sclk_d = sclk_o;
            if (tick) begin
               sclk_d = ~sclk_o;
               // edge_cnt is the edge number minus one, so its LSB picks odd/even edges
               if (edge_cnt[0] == cpha_q)
                  miso_d = 1'b1;
               else if (cpha_q || edge_cnt != 4'd15)
                  transmit_d = 1'b1;
            end
         end
         HOLD:  rxw_d = (div_cnt == '0);
         GAP: begin
            mux_d  = 1'b0;
            cs_n_d = 1'b1;
            done_d = (div_cnt == '0);
         end
         default: ;
      endcase
      if (abort) begin
         load_d     = 1'b0;
         first_d    = 1'b0;
         transmit_d = 1'b0;
         miso_d     = 1'b0;
         rxw_d      = 1'b0;
         done_d     = 1'b0;
         mux_d      = 1'b0;
         cs_n_d     = 1'b1;
         sclk_d     = cpol_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_shift_load_o    <= 1'b0;
         tx_fifo_read_o     <= 1'b0;
         mosi_first_en_o    <= 1'b0;
         mosi_transmit_en_o <= 1'b0;
         miso_en_o          <= 1'b0;
         mosi_mux_sel_o     <= 1'b0;
         rx_fifo_write_o    <= 1'b0;
         sclk_o             <= 1'b0;
         cs_n_o             <= 1'b1;
         busy_o             <= 1'b0;
         xfer_done_o        <= 1'b0;
      end else begin
         tx_shift_load_o    <= load_d;
         tx_fifo_read_o     <= load_d;
         mosi_first_en_o    <= first_d;
         mosi_transmit_en_o <= transmit_d;
         miso_en_o          <= miso_d;
         mosi_mux_sel_o     <= mux_d;
         rx_fifo_write_o    <= rxw_d;
         sclk_o             <= sclk_d;
         cs_n_o             <= cs_n_d;
         busy_o             <= busy_d;
         xfer_done_o        <= done_d;
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: loopback datapath stand-in, edge/strobe monitor and
// a byte-sequence reference (what goes into TX must come back out of RX, 16 edges per byte).
module tb_spi_controller;

   logic       clk = 1'b0;
   logic       rst_n, spi_en, cpol, cpha;
   logic [7:0] clk_div;
   logic       tx_fifo_empty;
   logic       tx_shift_load, tx_fifo_read, mosi_first_en, mosi_transmit_en, miso_en;
   logic       mosi_mux_sel, rx_fifo_write, sclk, cs_n, busy, xfer_done;

   spi_controller #(.CLK_DIV_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .spi_en_i(spi_en), .cpol_i(cpol), .cpha_i(cpha),
      .clk_div_i(clk_div), .tx_fifo_empty_i(tx_fifo_empty),
      .tx_shift_load_o(tx_shift_load), .tx_fifo_read_o(tx_fifo_read),
      .mosi_first_en_o(mosi_first_en), .mosi_transmit_en_o(mosi_transmit_en),
      .miso_en_o(miso_en), .mosi_mux_sel_o(mosi_mux_sel), .rx_fifo_write_o(rx_fifo_write),
      .sclk_o(sclk), .cs_n_o(cs_n), .busy_o(busy), .xfer_done_o(xfer_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // TX FIFO, shift registers and RX FIFO, with MOSI looped back to MISO
   logic [7:0] tx_mem [256];
   logic [7:0] rx_mem [256];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   logic [7:0] tx_sr = 8'd0;
   logic [7:0] rx_sr = 8'd0;
   logic       out_bit = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] exp_q [$];

   assign tx_fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (tx_shift_load) begin
         tx_sr  <= tx_mem[rd_ptr];
         rd_ptr <= rd_ptr + 8'd1;
      end
      if (mosi_first_en || mosi_transmit_en) begin
         out_bit <= tx_sr[7];
         tx_sr   <= {tx_sr[6:0], 1'b0};
      end
      if (miso_en) rx_sr <= {rx_sr[6:0], mosi_mux_sel & out_bit};
      if (rx_fifo_write) begin
         rx_mem[rx_cnt[7:0]] <= rx_sr;
         rx_cnt <= rx_cnt + 1;
      end
   end

   // Monitor: cumulative counters sampled on the falling edge
   int   cyc = 0, last_edge = 0, in_byte = 0;
   int   n_edge = 0, n_read = 0, n_write = 0, n_done = 0, n_first = 0;
   int   bad_iv = 0, bad_samp = 0, bad_mux = 0;
   int   busy_cyc = 0, strobe_cyc = 0, cs_low_cyc = 0;
   int   hi_len = 0, last_gap = 0;
   logic prev_sclk = 1'b0, prev_cs = 1'b1;
   logic edge_w, samp_w;
   int   nstrobe;

   always_comb begin
      edge_w  = !cs_n && (sclk != prev_sclk);
      // leading edges leave the idle level; CPHA=0 samples on them, CPHA=1 on the others
      samp_w  = edge_w && ((sclk ^ cpol) != cpha);
      nstrobe = int'(tx_shift_load) + int'(mosi_first_en) + int'(mosi_transmit_en)
              + int'(miso_en) + int'(rx_fifo_write) + int'(xfer_done);
   end

   always @(negedge clk) begin
      cyc       <= cyc + 1;
      prev_sclk <= sclk;
      prev_cs   <= cs_n;
      if (edge_w) begin
         n_edge <= n_edge + 1;
         if (in_byte > 0 && (cyc - last_edge) != int'(clk_div) + 1) bad_iv <= bad_iv + 1;
         last_edge <= cyc;
         in_byte   <= in_byte + 1;
      end
      if (cs_n) in_byte <= 0;
      if ((miso_en != samp_w) || (mosi_transmit_en && (!edge_w || samp_w))) bad_samp <= bad_samp + 1;
      if (nstrobe > 1 || tx_shift_load != tx_fifo_read) bad_mux <= bad_mux + 1;
      n_read     <= n_read + int'(tx_fifo_read);
      n_write    <= n_write + int'(rx_fifo_write);
      n_done     <= n_done + int'(xfer_done);
      n_first    <= n_first + int'(mosi_first_en);
      busy_cyc   <= busy_cyc + int'(busy);
      cs_low_cyc <= cs_low_cyc + int'(!cs_n);
      strobe_cyc <= strobe_cyc + int'(nstrobe != 0 || tx_fifo_read);
      if (cs_n && !prev_cs) hi_len <= 1;
      else if (cs_n) hi_len <= hi_len + 1;
      if (!cs_n && prev_cs) last_gap <= hi_len;
   end

   task automatic push(input logic [7:0] b, input bit expect_rx);
      tx_mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 8'd1;
      if (expect_rx) exp_q.push_back(b);
   endtask

   task automatic set_mode(input logic cp, input logic ch, input logic [7:0] dv);
      @(negedge clk);
      cpol = cp;
      cpha = ch;
      clk_div = dv;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_cs_n"}, cs_n, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_strobes"}, {tx_shift_load, tx_fifo_read, mosi_first_en, mosi_transmit_en,
                                miso_en, rx_fifo_write, xfer_done}, 0);
   endtask

   // Runs the bytes already queued with expect_rx=1 and checks them against the reference
   task automatic run_xfer(input string tag, input int nb);
      int e0, r0, w0, d0, f0, iv0, s0, m0, rx0, budget, t;
      e0 = n_edge; r0 = n_read; w0 = n_write; d0 = n_done; f0 = n_first;
      iv0 = bad_iv; s0 = bad_samp; m0 = bad_mux; rx0 = rx_cnt;
      budget = nb * (20 * (int'(clk_div) + 1) + 4) + 40;
      t = 0;
      spi_en = 1'b1;
      while (n_done - d0 < nb && t < budget) begin
         @(negedge clk); #1;
         t++;
      end
      check({tag, "_in_time"}, int'(t < budget), 1);
      repeat (2 * (int'(clk_div) + 1) + 4) @(negedge clk);
      #1;
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_edges"}, n_edge - e0, 16 * nb);
      check({tag, "_half_period"}, bad_iv - iv0, 0);
      check({tag, "_sample_shift"}, bad_samp - s0, 0);
      check({tag, "_exclusive"}, bad_mux - m0, 0);
      check({tag, "_reads"}, n_read - r0, nb);
      check({tag, "_writes"}, n_write - w0, nb);
      check({tag, "_done"}, n_done - d0, nb);
      check({tag, "_first_en"}, n_first - f0, cpha ? 0 : nb);
      for (int i = 0; i < nb; i++) begin
         logic [7:0] e;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         check({tag, "_rx"}, int'(rx_mem[8'(rx0 + i)]), int'(e));
      end
      spi_en = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, w0, d0, b0, st0, cl0, t;
      rst_n = 1'b0; spi_en = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      check("reset_sclk", sclk, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // T1 mode 0, fastest SCLK
      set_mode(1'b0, 1'b0, 8'd0);
      push(8'hA5, 1'b1);
      run_xfer("t1", 1);

      // T2 mode 3, half-period 4
      set_mode(1'b1, 1'b1, 8'd3);
      check("t2_sclk_idle", sclk, 1);
      push(8'h3C, 1'b1);
      run_xfer("t2", 1);

      // T3 back-to-back bytes
      set_mode(1'b0, 1'b1, 8'd1);
      push(8'h11, 1'b1);
      push(8'h22, 1'b1);
      run_xfer("t3", 2);
      check("t3_cs_gap", last_gap, int'(clk_div) + 1);

      // T4 enabled with nothing to send
      set_mode(1'b0, 1'b0, 8'd0);
      b0 = busy_cyc; st0 = strobe_cyc; cl0 = cs_low_cyc;
      spi_en = 1'b1;
      repeat (100) @(negedge clk);
      #1;
      check("t4_busy", busy_cyc - b0, 0);
      check("t4_strobes", strobe_cyc - st0, 0);
      check("t4_cs_low", cs_low_cyc - cl0, 0);
      spi_en = 1'b0;

      // T5 abort after edge 5
      set_mode(1'b1, 1'b0, 8'd2);
      push(8'hC3, 1'b0);
      e0 = n_edge; w0 = n_write; d0 = n_done; t = 0;
      spi_en = 1'b1;
      while (n_edge - e0 < 5 && t < 500) begin
         @(negedge clk); #1;
         t++;
      end
      check("t5_reach_edge5", int'(t < 500), 1);
      spi_en = 1'b0;
      @(posedge clk); #1;
      check("t5_cs_n", cs_n, 1);
      check("t5_sclk", sclk, 1);
      check("t5_busy", busy, 0);
      repeat (20) @(negedge clk);
      #1;
      check("t5_no_write", n_write - w0, 0);
      check("t5_no_done", n_done - d0, 0);
      check("t5_edges", n_edge - e0, 5);

      // T6 reset mid-SHIFT
      set_mode(1'b1, 1'b1, 8'd1);
      push(8'h5A, 1'b0);
      e0 = n_edge; t = 0;
      spi_en = 1'b1;
      while (n_edge - e0 < 3 && t < 500) begin
         @(negedge clk); #1;
         t++;
      end
      check("t6_reach_shift", int'(t < 500), 1);
      rst_n = 1'b0;
      check("t6_cs_before_edge", cs_n, 0);
      @(posedge clk); #1;
      check_idle_outputs("t6");
      check("t6_sclk", sclk, 0);
      @(negedge clk);
      rst_n = 1'b1;
      spi_en = 1'b0;

      // Randomized modes, dividers and byte counts
      for (int k = 0; k < 8; k++) begin
         int nb;
         set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)));
         nb = $urandom_range(1, 3);
         for (int i = 0; i < nb; i++) push(8'($urandom), 1'b1);
         run_xfer("rnd", nb);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
